// File: rtl/dff_prbs_checker.sv
// PRBS7 (x^7+x^6+1) stream checker for the DFF under characterisation.
// Self-synchronises on the incoming bits, then counts bits and errors over a programmed length.
module dff_prbs_checker #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_THRESH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_q,
  input  logic             i_valid,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_lock,
  output logic             o_done,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_err,
  output logic [CNT_W-1:0] o_first_err_idx
);

  localparam logic [CNT_W-1:0] LockThresh = CNT_W'(LOCK_THRESH);

  typedef enum logic [1:0] {StIdle, StSync, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [6:0]       s_q, s_d;
  logic [2:0]       fill_q, fill_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             done_q, done_d;

  logic             pred;
  logic [6:0]       s_load;
  logic [CNT_W-1:0] match_nxt;
  logic [CNT_W-1:0] bit_cnt_inc;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = err_q;
    first_d     = first_q;
    done_d      = 1'b0;
    pred        = s_q[6] ^ s_q[5];
    s_load      = {s_q[5:0], i_q};
    match_nxt   = (i_q == pred) ? match_q + 1'b1 : '0;
    bit_cnt_inc = bit_cnt_q + 1'b1;

    case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          len_d     = i_len;
          bit_cnt_d = '0;
          err_cnt_d = '0;
          err_d     = 1'b0;
          first_d   = '0;
          s_d       = '0;
          fill_d    = '0;
          match_d   = '0;
          if (i_len == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StSync;
          end
        end
      end
      StSync: begin
        if (i_valid) begin
          s_d = s_load;
          if (fill_q != 3'd7) begin
            fill_d = fill_q + 3'd1;
          end else if (s_load == '0) begin
            // A fully loaded all-zero register would predict zeros forever; refill instead.
            fill_d  = '0;
            match_d = '0;
          end else begin
            match_d = match_nxt;
            if (match_nxt == LockThresh) begin
              state_d = StCheck;
            end
          end
        end
      end
      StCheck: begin
        if (i_valid) begin
          s_d       = {s_q[5:0], pred};
          bit_cnt_d = bit_cnt_inc;
          if (i_q != pred) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            err_d = 1'b1;
            if (!err_q) begin
              first_d = bit_cnt_q;
            end
          end
          if (bit_cnt_inc == len_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      s_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      first_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      first_q   <= first_d;
      done_q    <= done_d;
    end
  end

  assign o_busy          = (state_q == StSync) || (state_q == StCheck);
  assign o_lock          = (state_q == StCheck);
  assign o_done          = done_q;
  assign o_bit_cnt       = bit_cnt_q;
  assign o_err_cnt       = err_cnt_q;
  assign o_err           = err_q;
  assign o_first_err_idx = first_q;

endmodule

// File: tb/tb_dff_prbs_checker.sv
// Directed bench for dff_prbs_checker: a 16-bit instance and a 4-bit instance,
// expected run results queued at start and compared when o_done pulses.
module tb_dff_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, q, valid, start;
  logic [15:0] len;
  logic        busy, lock, done, err;
  logic [15:0] bit_cnt, err_cnt, first;

  logic        s_q, s_valid, s_start;
  logic [3:0]  s_len;
  logic        s_busy, s_lock, s_done, s_err;
  logic [3:0]  s_bit_cnt, s_err_cnt, s_first;

  dff_prbs_checker #(.CNT_W(16), .LOCK_THRESH(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_q(q), .i_valid(valid), .i_start(start), .i_len(len),
    .o_busy(busy), .o_lock(lock), .o_done(done), .o_bit_cnt(bit_cnt), .o_err_cnt(err_cnt),
    .o_err(err), .o_first_err_idx(first)
  );

  dff_prbs_checker #(.CNT_W(4), .LOCK_THRESH(8)) u_dut_small (
    .i_clk(clk), .i_rst(rst), .i_q(s_q), .i_valid(s_valid), .i_start(s_start), .i_len(s_len),
    .o_busy(s_busy), .o_lock(s_lock), .o_done(s_done), .o_bit_cnt(s_bit_cnt),
    .o_err_cnt(s_err_cnt), .o_err(s_err), .o_first_err_idx(s_first)
  );

  typedef struct {
    string tag;
    int    bc;
    int    ec;
    int    er;
    int    fi;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_bit(inout logic [6:0] g, output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic compare_result(input logic [31:0] bc, input logic [31:0] ec,
                                input logic [31:0] er, input logic [31:0] fi);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_bit_cnt"}, bc, e.bc);
      chk({e.tag, "_err_cnt"}, ec, e.ec);
      chk({e.tag, "_err"}, er, e.er);
      chk({e.tag, "_first_idx"}, fi, e.fi);
    end
  endtask

  // inv_idx: check index to corrupt (negative = none); gaps: valid every other cycle;
  // start_mid: pulse i_start with a short length while in CHECK.
  task automatic run_big(input string tag, input int n_len, input int inv_idx,
                         input bit gaps, input bit start_mid);
    logic [6:0] g;
    logic       b;
    int         n, cyc;
    bit         got;
    exp_t       e;
    g = 7'h7F; n = 0; cyc = 0; got = 1'b0;
    e.tag = tag;
    e.bc  = n_len;
    e.ec  = (inv_idx >= 0 && inv_idx < n_len) ? 1 : 0;
    e.er  = e.ec;
    e.fi  = (e.ec != 0) ? inv_idx : 0;
    sb.push_back(e);
    start = 1'b1; len = 16'(n_len); valid = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, "_busy_sync"}, {31'd0, busy}, 1);
    while (!got && cyc < 2000) begin
      cyc++;
      if (gaps && (cyc % 2 == 0)) begin
        valid = 1'b0;
        tick();
      end else begin
        gen_bit(g, b);
        if (n - 23 == inv_idx) b = ~b;
        q = b; valid = 1'b1;
        if (start_mid && n == 50) begin
          start = 1'b1; len = 16'd5;
        end
        tick();
        start = 1'b0;
        n++;
        if (n == 22) chk({tag, "_lock_early"}, {31'd0, lock}, 0);
        if (n == 23) chk({tag, "_lock"}, {31'd0, lock}, 1);
        if (done) begin
          got = 1'b1;
          chk({tag, "_done_at"}, n, 23 + n_len);
          compare_result(bit_cnt, err_cnt, {31'd0, err}, first);
        end
      end
    end
    valid = 1'b0;
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
      void'(sb.pop_back());
    end
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
    chk({tag, "_busy_done"}, {31'd0, busy}, 0);
    chk({tag, "_hold"}, bit_cnt, n_len);
  endtask

  initial begin
    logic [6:0] g;
    logic       b;
    int         n;
    bit         got, seen_lock, seen_done;
    exp_t       e;

    rst = 1'b1; q = 1'b0; valid = 1'b0; start = 1'b0; len = '0;
    s_q = 1'b0; s_valid = 1'b0; s_start = 1'b0; s_len = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_cnts", {bit_cnt, err_cnt}, 0);
    chk("rst_small", {s_busy, s_lock, s_done, s_err, s_bit_cnt, s_err_cnt, s_first}, 0);
    rst = 1'b0;
    tick();

    run_big("clean", 100, -100, 1'b0, 1'b0);
    run_big("inv40", 100, 40, 1'b0, 1'b1);
    run_big("gaps", 100, -100, 1'b1, 1'b0);

    // Zero length completes immediately
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    chk("len0_done", {31'd0, done}, 1);
    chk("len0_counts", {bit_cnt, err_cnt}, 0);
    chk("len0_busy", {31'd0, busy}, 0);
    tick();
    chk("len0_pulse", {31'd0, done}, 0);

    // Reset in the middle of CHECK abandons the run
    g = 7'h7F;
    start = 1'b1; len = 16'd100;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      gen_bit(g, b);
      q = b; valid = 1'b1;
      tick();
    end
    chk("mid_lock", {31'd0, lock}, 1);
    chk("mid_bits", bit_cnt, 7);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; valid = 1'b0;
    chk("mid_rst_outs", {busy, lock, done, err, bit_cnt, err_cnt, first}, 0);
    tick();
    chk("mid_rst_idle", {31'd0, busy}, 0);

    // All-zero stream never locks
    start = 1'b1; len = 16'd10;
    tick();
    start = 1'b0;
    seen_lock = 1'b0; seen_done = 1'b0;
    q = 1'b0; valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (lock) seen_lock = 1'b1;
      if (done) seen_done = 1'b1;
    end
    valid = 1'b0;
    chk("zero_lock", {31'd0, seen_lock}, 0);
    chk("zero_done", {31'd0, seen_done}, 0);
    chk("zero_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Narrow counters: lock after 7+8 bits, then every bit inverted
    e.tag = "sat"; e.bc = 15; e.ec = 15; e.er = 1; e.fi = 0;
    sb.push_back(e);
    g = 7'h7F; n = 0; got = 1'b0;
    s_start = 1'b1; s_len = 4'd15;
    tick();
    s_start = 1'b0;
    while (!got && n < 200) begin
      gen_bit(g, b);
      s_q = (n >= 15) ? ~b : b;
      s_valid = 1'b1;
      tick();
      n++;
      if (n == 15) chk("sat_lock", {31'd0, s_lock}, 1);
      if (s_done) begin
        got = 1'b1;
        chk("sat_done_at", n, 30);
        compare_result({28'd0, s_bit_cnt}, {28'd0, s_err_cnt}, {31'd0, s_err},
                       {28'd0, s_first});
      end
    end
    s_valid = 1'b0;
    if (!got) begin
      chk("sat_timeout", 0, 1);
      void'(sb.pop_back());
    end
    tick();
    chk("sat_pulse", {31'd0, s_done}, 0);
    chk("sat_hold", {28'd0, s_err_cnt}, 15);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
